div_seq_restoring: RTL and testbench
====================================

// Module: div_seq_restoring
// PURPOSE
//  Sequential unsigned restoring divider: the shift-subtract counterpart of the shift-add multiplier.
//  Control FSM and datapath are in one block. One quotient bit is produced per clock.
//  Sits beside the multiplier in the ALU. Uses the same St/done start-finish handshake, so the
//  ALU sequencer can drive both units the same way.
// PARAMETERS
//  WIDTH  8  operand width in bits (dividend, divisor, quotient, remainder); WIDTH >= 2
// PORTS
//  clk        in   1      rising-edge clock; the only clock
//  rst_n      in   1      synchronous, active-low reset
//  St         in   1      start request; level-sampled in IDLE
//  dividend   in   WIDTH  unsigned numerator; sampled only on the accept edge
//  divisor    in   WIDTH  unsigned denominator; sampled only on the accept edge
//  quotient   out  WIDTH  result; valid while done=1, held until the next accept
//  remainder  out  WIDTH  result; valid while done=1, held until the next accept
//  busy       out  1      1 in CALC
//  done       out  1      1 in DONE only
//  div_zero   out  1      1 in DONE when the accepted divisor was 0
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE; R, Q, count, quotient, remainder, div_zero cleared to 0.
//   busy=0 and done=0. Reset wins over every other condition, including mid-CALC; the partial result is discarded.
//  States (2-bit register):
//   IDLE=0: St=1 -> accept.
//    If divisor!=0: R<=0 (WIDTH+1 bits), Q<=dividend, D<=divisor, count<=WIDTH-1, div_zero<=0, go to CALC.
//    If divisor==0: quotient<={WIDTH{1}}, remainder<=dividend, div_zero<=1, go to DONE.
//    St=0 -> stay in IDLE.
//   CALC=1: each edge performs one step:
//    shift {R,Q} left by 1 -> {Rs,Qs}; T = Rs - {1'b0,D} (WIDTH+1 bits).
//    If T[WIDTH]==0: R<=T and Q<={Qs[WIDTH-1:1],1}. Otherwise R<=Rs and Q<={Qs[WIDTH-1:1],0}.
//    When count==0: register quotient<=next Q and remainder<=next R[WIDTH-1:0], go to DONE.
//    Otherwise count<=count-1.
//    St and operand inputs are ignored in CALC.
//   DONE=2: done=1; outputs are held. St=0 -> go to IDLE. St=1 -> stay in DONE.
//    A level-held St cannot retrigger the divider.
//   3: illegal; go to IDLE. All outputs read 0 except quotient and remainder, which are held.
//  Outputs are a Moore decode of state (busy, done) plus registered results. There is no combinational input->output path.
//  Latency: accept edge at cycle 0 -> WIDTH CALC edges -> done=1 after edge WIDTH+1. For divisor=0, done=1 after edge 1.
//  Throughput: one division per WIDTH+2 cycles minimum, because St must drop for one cycle between operations.
//  Invariants after completion: dividend == quotient*divisor + remainder, and remainder < divisor.
//  Arithmetic is unsigned only. R is WIDTH+1 bits so the trial subtract never overflows.
//  count is clog2(WIDTH) bits wide.
// STRUCTURE
//  div_pkg (include file): state encodings S_IDLE/S_CALC/S_DONE and the div-by-zero quotient constant.
//  One sub-module, div_step: combinational single shift/trial-subtract step; inputs R, Q, D; outputs next R, next Q.
//  The top level holds the FSM, count, operand registers and result registers.
// TESTING (WIDTH=8)
//  1. 100/7, St pulsed one cycle -> quotient=14, remainder=2, div_zero=0; done rises after exactly 9 edges; busy=1 for 8 cycles.
//  2. Boundaries -> 255/1: quotient=255, remainder=0. 5/9: quotient=0, remainder=5. 255/255: quotient=1, remainder=0. 0/3: quotient=0, remainder=0.
//  3. 37/0 -> done after 1 edge; quotient=8'hFF, remainder=37, div_zero=1, busy never 1.
//  4. St held high through the whole operation -> one division only; done stays 1 until St=0, then IDLE.
//   A second St starts a fresh operation with div_zero cleared.
//  5. rst_n=0 at the 4th CALC cycle -> next edge: IDLE with all outputs 0.
//   A new 200/13 then gives quotient=15, remainder=5.
//  6. Dividend/divisor changed every cycle during CALC -> result equals the operands sampled at accept.
//   Random sweep of 1000 pairs is checked against q*d+r==n and r<d.

Source files
------------

// File: rtl/div_seq_restoring_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings
// and the quotient pattern reported on a divide-by-zero.
package div_seq_restoring_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CALC    = 2'd1,
        S_DONE    = 2'd2,
        S_ILLEGAL = 2'd3
    } state_t;

    // Truncated to the operand width at the point of use, so any WIDTH gets all ones.
    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_seq_restoring_if.sv
// Start/done handshake and operand/result bundle shared by the divider and
// the ALU sequencer that drives it.
interface div_seq_restoring_if #(
    parameter int WIDTH = 8
);
    logic             St;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output St, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  St, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );
endinterface

// File: rtl/div_seq_restoring_step.sv
// One combinational restoring-division step: shift {R,Q} left, trial-subtract
// the divisor, and keep the difference only when it did not go negative.
module div_seq_restoring_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0] rs;
    logic [WIDTH:0] trial;

    // R stays below D between steps, so its MSB is always zero before the shift.
    logic unused_r_msb;
    assign unused_r_msb = r[WIDTH];

    always_comb begin
        rs     = {r[WIDTH-1:0], q[WIDTH-1]};
        trial  = rs - {1'b0, d};
        r_next = trial[WIDTH] ? rs : trial;
        q_next = {q[WIDTH-2:0], ~trial[WIDTH]};
    end
endmodule

// File: rtl/div_seq_restoring.sv
// Sequential unsigned restoring divider, one quotient bit per clock, driven
// through the same St/done handshake as the shift-add multiplier.
module div_seq_restoring
    import div_seq_restoring_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    div_seq_restoring_if.slave bus
);
    localparam int             CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]  COUNT_INIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             div_zero_reg;

    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    div_seq_restoring_step #(.WIDTH(WIDTH)) step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (r_next),
        .q_next (q_next)
    );

    // busy/done are registered alongside the state so they are a clean decode of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            r_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            count         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            div_zero_reg  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.St) begin
                        if (bus.divisor != '0) begin
                            r_reg        <= '0;
                            q_reg        <= bus.dividend;
                            d_reg        <= bus.divisor;
                            count        <= COUNT_INIT;
                            div_zero_reg <= 1'b0;
                            busy_reg     <= 1'b1;
                            done_reg     <= 1'b0;
                            state        <= S_CALC;
                        end else begin
                            quotient_reg  <= WIDTH'(DIV_ZERO_QUOTIENT);
                            remainder_reg <= bus.dividend;
                            div_zero_reg  <= 1'b1;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            state         <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    if (count == '0) begin
                        quotient_reg  <= q_next;
                        remainder_reg <= r_next[WIDTH-1:0];
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                S_DONE: begin
                    // Holding St here parks the unit; it needs a low cycle to re-arm.
                    if (!bus.St) begin
                        done_reg     <= 1'b0;
                        div_zero_reg <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b0;
                    div_zero_reg <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.div_zero  = div_zero_reg;
endmodule

// File: tb/tb_div_seq_restoring.sv
// Scoreboard bench for div_seq_restoring: the driver queues expected results,
// a monitor compares them whenever done rises.
module tb_div_seq_restoring;

    typedef struct {
        logic [7:0] n;
        logic [7:0] d;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   assertions;
    int   failures;
    exp_t sb[$];

    div_seq_restoring_if #(.WIDTH(8)) bus ();

    div_seq_restoring #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one division, scrambling the operand inputs while it runs.
    task automatic apply_stimulus(input logic [7:0] n, input logic [7:0] d,
                                  input logic [7:0] q, input logic [7:0] r,
                                  input logic z, input bit hold);
        int edges;
        int busy_cycles;
        sb.push_back('{n: n, d: d, q: q, r: r, z: z});
        bus.St       = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        edges        = 0;
        busy_cycles  = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (!hold) bus.St = 1'b0;
            bus.dividend = 8'($urandom);
            bus.divisor  = 8'($urandom);
            if (bus.busy) busy_cycles++;
        end while (!bus.done && edges < 40);
        check_output("latency_edges", edges, (d == 8'd0) ? 1 : 9);
        check_output("busy_cycles", busy_cycles, (d == 8'd0) ? 0 : 8);
        if (hold) begin
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            check_output("held_done_busy", {bus.done, bus.busy}, 2'b10);
        end
        bus.St = 1'b0;
        @(posedge clk);
        #1;
        check_output("return_idle", {bus.busy, bus.done, bus.div_zero}, 3'b000);
    endtask

    initial begin : monitor
        exp_t e;
        logic done_seen;
        done_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done && !done_seen) begin
                assertions++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_done: q=%0d r=%0d with empty scoreboard",
                             bus.quotient, bus.remainder);
                end else begin
                    e = sb.pop_front();
                    if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_zero !== e.z) begin
                        failures++;
                        $display("[TB] FAIL result %0d/%0d: got q=%0d r=%0d z=%0b, expected q=%0d r=%0d z=%0b",
                                 e.n, e.d, bus.quotient, bus.remainder, bus.div_zero, e.q, e.r, e.z);
                    end
                    if (e.d != 8'd0) begin
                        assertions++;
                        if (int'(bus.quotient) * int'(e.d) + int'(bus.remainder) != int'(e.n)
                            || bus.remainder >= e.d) begin
                            failures++;
                            $display("[TB] FAIL invariant %0d/%0d: got q=%0d r=%0d, expected q*d+r=n and r<d",
                                     e.n, e.d, bus.quotient, bus.remainder);
                        end
                    end
                end
            end
            done_seen = bus.done;
        end
    end

    initial begin : driver
        logic [7:0] n;
        logic [7:0] d;
        assertions   = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.St       = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_state",
                     {bus.busy, bus.done, bus.div_zero, bus.quotient, bus.remainder}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic and boundary divisions");
        apply_stimulus(8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 1'b0);
        apply_stimulus(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 1'b0);
        apply_stimulus(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 1'b0);
        apply_stimulus(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 1'b0);
        apply_stimulus(8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 1'b0);
        apply_stimulus(8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 1'b0);

        $display("[TB] St held through the operation");
        apply_stimulus(8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 1'b1);
        apply_stimulus(8'd37,  8'd0,   8'hFF,  8'd37, 1'b1, 1'b1);
        apply_stimulus(8'd50,  8'd5,   8'd10,  8'd0,  1'b0, 1'b0);

        $display("[TB] reset during CALC");
        bus.St       = 1'b1;
        bus.dividend = 8'd77;
        bus.divisor  = 8'd3;
        @(posedge clk);
        #1;
        bus.St = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_output("busy_before_abort", bus.busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("abort_outputs",
                     {bus.busy, bus.done, bus.div_zero, bus.quotient, bus.remainder}, 0);
        rst_n = 1'b1;
        apply_stimulus(8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 1'b0);

        $display("[TB] random sweep");
        for (int i = 0; i < 1000; i++) begin
            n = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            if (d == 8'd0)
                apply_stimulus(n, d, 8'hFF, n, 1'b1, 1'b0);
            else
                apply_stimulus(n, d, n / d, n % d, 1'b0, 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        check_output("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
